// File: rtl/timer_int_pkg.sv
// Shared types and constants for the timer interrupt arbiter.
// State encoding, TIFR bit map, default vector layout, vector helper.
package timer_int_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_CLEAR,
    S_GAP
  } arb_state_e;

  localparam int OCF2  = 7;
  localparam int TOV2  = 6;
  localparam int ICF1  = 5;
  localparam int OCF1A = 4;
  localparam int OCF1B = 3;
  localparam int TOV1  = 2;
  localparam int OCF0  = 1;
  localparam int TOV0  = 0;

  localparam logic [7:0] DEF_VECTOR_BASE   = 8'h08;
  localparam int         DEF_VECTOR_STRIDE = 2;

  // Bit 7 sits at the base; lower bits move up by one stride each.
  function automatic logic [7:0] vec_addr(
    input logic [7:0] base,
    input logic [7:0] stride,
    input logic [2:0] idx
  );
    logic [7:0] slot;
    slot = 8'd7 - {5'd0, idx};
    return base + stride * slot;
  endfunction

endpackage

// File: rtl/timer_interrupt_arbiter_priority_encoder_8.sv
// 8-bit priority encoder, highest set bit wins.
// Ports: req[7:0] in; idx[2:0] winning bit, valid = any bit set.
module priority_encoder_8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/timer_interrupt_arbiter.sv
// Prioritises timer TIFR/TIMSK flags into one CPU irq with vector.
// Ports: sysClock, system_reset, TIFR_input, TIMSK_input,
//   global_int_enable, irq_ack -> irq, irq_vector,
//   TIFR_clear_mask, TIFR_clear_enable, busy (all registered).
module timer_interrupt_arbiter
  import timer_int_pkg::*;
#(
  parameter logic [7:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int         VECTOR_STRIDE = DEF_VECTOR_STRIDE,
  parameter int         GAP_CYCLES    = 1
) (
  input  logic       sysClock,
  input  logic       system_reset,
  input  logic [7:0] TIFR_input,
  input  logic [7:0] TIMSK_input,
  input  logic       global_int_enable,
  input  logic       irq_ack,
  output logic       irq,
  output logic [7:0] irq_vector,
  output logic [7:0] TIFR_clear_mask,
  output logic       TIFR_clear_enable,
  output logic       busy
);

  localparam logic [3:0] GAP_W    = 4'(GAP_CYCLES);
  localparam logic [7:0] STRIDE_W = 8'(VECTOR_STRIDE);

  arb_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;

  logic       irq_d;
  logic [7:0] vec_d;
  logic [7:0] mask_d;
  logic       clr_d;
  logic       busy_d;

  logic [7:0] pending;
  logic [2:0] pend_idx;
  logic       pend_valid;

  assign pending = TIFR_input & TIMSK_input
                 & {8{global_int_enable}};

  priority_encoder_8 u_penc (
    .req   (pending),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    irq_d   = irq;
    vec_d   = irq_vector;
    mask_d  = '0;
    clr_d   = 1'b0;
    busy_d  = busy;
    unique case (state_q)
      S_IDLE: begin
        if (pend_valid) begin
          state_d = S_REQUEST;
          idx_d   = pend_idx;
          irq_d   = 1'b1;
          vec_d   = vec_addr(VECTOR_BASE, STRIDE_W,
                             pend_idx);
          busy_d  = 1'b1;
        end
      end
      S_REQUEST: begin
        // Ack takes precedence over a simultaneous withdraw.
        if (irq_ack) begin
          state_d = S_CLEAR;
          irq_d   = 1'b0;
          vec_d   = '0;
          clr_d   = 1'b1;
          mask_d  = 8'b1 << idx_q;
        end else if (!pending[idx_q]) begin
          state_d = S_IDLE;
          irq_d   = 1'b0;
          vec_d   = '0;
          busy_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_GAP;
        gap_d   = GAP_W;
      end
      S_GAP: begin
        // Holds off arbitration while the cleared flag settles.
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          gap_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (system_reset) begin
      state_q           <= S_IDLE;
      idx_q             <= '0;
      gap_q             <= '0;
      irq               <= 1'b0;
      irq_vector        <= '0;
      TIFR_clear_mask   <= '0;
      TIFR_clear_enable <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      gap_q             <= gap_d;
      irq               <= irq_d;
      irq_vector        <= vec_d;
      TIFR_clear_mask   <= mask_d;
      TIFR_clear_enable <= clr_d;
      busy              <= busy_d;
    end
  end

endmodule

// File: tb/tb_timer_interrupt_arbiter.sv
// Testbench for timer_interrupt_arbiter.
// Directed test-plan steps then random traffic against a reference model.
module tb_timer_interrupt_arbiter;

  localparam int GAP = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tifr;
  logic [7:0] timsk;
  logic       gie;
  logic       ack;
  logic       irq;
  logic [7:0] irq_vector;
  logic [7:0] clr_mask;
  logic       clr_en;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: observable outputs plus which flag is owned
  // and how many hold-off cycles remain before arbitration resumes.
  logic       m_irq;
  logic [7:0] m_vec;
  logic [7:0] m_mask;
  logic       m_clr;
  logic       m_busy;
  int         m_cur;
  int         m_wait;

  always #5 clk = ~clk;

  timer_interrupt_arbiter dut (
    .sysClock          (clk),
    .system_reset      (rst),
    .TIFR_input        (tifr),
    .TIMSK_input       (timsk),
    .global_int_enable (gie),
    .irq_ack           (ack),
    .irq               (irq),
    .irq_vector        (irq_vector),
    .TIFR_clear_mask   (clr_mask),
    .TIFR_clear_enable (clr_en),
    .busy              (busy)
  );

  function automatic int top_bit(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] p;
    p = tifr & timsk & {8{gie}};
    if (rst) begin
      m_irq = 0; m_vec = 0; m_mask = 0; m_clr = 0; m_busy = 0;
      m_cur = -1; m_wait = 0;
    end else if (m_clr) begin
      m_clr = 0; m_mask = 0; m_wait = GAP;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_busy = 0;
    end else if (m_irq) begin
      if (ack) begin
        m_irq = 0; m_vec = 0; m_clr = 1;
        m_mask = 8'(1 << m_cur);
      end else if (!p[m_cur]) begin
        m_irq = 0; m_vec = 0; m_busy = 0;
      end
    end else if (p != 0) begin
      m_cur  = top_bit(p);
      m_irq  = 1;
      m_vec  = 8'(8 + 2 * (7 - m_cur));
      m_busy = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("irq",  {7'd0, irq},    {7'd0, m_irq});
    chk("vec",  irq_vector,     m_vec);
    chk("mask", clr_mask,       m_mask);
    chk("clr",  {7'd0, clr_en}, {7'd0, m_clr});
    chk("busy", {7'd0, busy},   {7'd0, m_busy});
  endtask

  task automatic drive(input logic [7:0] f,
                       input logic [7:0] m,
                       input logic i);
    tifr = f; timsk = m; gie = i;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0;
    drive(8'h00, 8'h00, 1'b0);
    #2;
    tick();
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_vec", irq_vector, 8'h00);
    rst = 1'b0;
    tick();

    // Two flags: bit1 then bit0 after clear.
    drive(8'h03, 8'h03, 1'b1);
    tick();
    chk("t1_vec", irq_vector, 8'h14);
    pulse_ack();
    chk("t1_clr", {7'd0, clr_en}, 8'h01);
    chk("t1_mask", clr_mask, 8'h02);
    tifr = 8'h01;
    repeat (GAP + 2) tick();
    chk("t1_vec0", irq_vector, 8'h16);
    pulse_ack();
    chk("t1_mask0", clr_mask, 8'h01);
    tifr = 8'h00;
    repeat (GAP + 2) tick();

    // Masked flag, then enabled.
    drive(8'h80, 8'h00, 1'b1);
    repeat (2) tick();
    chk("t2_noirq", {7'd0, irq}, 8'h00);
    timsk = 8'h80;
    tick();
    chk("t2_vec", irq_vector, 8'h08);
    pulse_ack();
    tifr = 8'h00;
    repeat (GAP + 2) tick();

    // Global disable, then withdraw before ack.
    drive(8'h01, 8'h01, 1'b0);
    repeat (2) tick();
    chk("t3_noirq", {7'd0, irq}, 8'h00);
    gie = 1'b1;
    tick();
    chk("t3_vec", irq_vector, 8'h16);
    tifr = 8'h00;
    tick();
    chk("t3_wd", {7'd0, irq}, 8'h00);
    repeat (2) tick();
    chk("t3_noclr", {7'd0, clr_en}, 8'h00);

    // No re-arbitration while requesting.
    drive(8'h01, 8'hFF, 1'b1);
    tick();
    tifr = 8'h81;
    repeat (2) tick();
    chk("t4_frozen", irq_vector, 8'h16);
    pulse_ack();
    tifr = 8'h80;
    repeat (GAP + 2) tick();
    chk("t4_vec7", irq_vector, 8'h08);
    pulse_ack();
    tifr = 8'h00;
    repeat (GAP + 2) tick();

    // Ack and withdraw together.
    tifr = 8'h01;
    tick();
    tifr = 8'h00;
    pulse_ack();
    chk("t5_clr", {7'd0, clr_en}, 8'h01);
    chk("t5_mask", clr_mask, 8'h01);
    repeat (GAP + 2) tick();

    // Reset during request.
    tifr = 8'h01;
    tick();
    rst = 1'b1;
    tick();
    chk("t6_irq", {7'd0, irq}, 8'h00);
    chk("t6_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    tick();
    chk("t6_reirq", {7'd0, irq}, 8'h01);

    // Random traffic; TIFR clears are emulated from the model strobe.
    for (int n = 0; n < 400; n++) begin
      if (m_clr) tifr = tifr & ~m_mask;
      if ($urandom_range(0, 3) == 0) tifr = tifr | 8'($urandom);
      if ($urandom_range(0, 5) == 0) tifr = tifr & 8'($urandom);
      if ($urandom_range(0, 9) == 0) timsk = 8'($urandom);
      if ($urandom_range(0, 19) == 0) gie = ~gie;
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    ack = 1'b0;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
